// File: rtl/fp_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_gpio_pkg
// Brief    : Shared state encoding and default widths/masks for fp_gpio_sched.
// Revision : 1.0
// ============================================================================
package fp_gpio_pkg;

   localparam int          C_GPIO_REG_WIDTH = 12;
   localparam logic [11:0] C_OUT_MASK       = 12'h011;
   localparam logic [11:0] C_IO_DDR         = 12'h011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GUARD = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_gpio_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or after ptr+1.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         grant,
   output logic [$clog2(NUM_REQ)-1:0] idx,
   output logic                       any
);

   localparam int C_IW = $clog2(NUM_REQ);

   int              w_cand;
   logic [C_IW-1:0] w_cand_idx;

   always_comb begin
      grant      = '0;
      idx        = '0;
      any        = 1'b0;
      w_cand     = 0;
      w_cand_idx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_cand     = (int'(ptr) + k) % NUM_REQ;
         w_cand_idx = C_IW'(w_cand);
         if (!any && req[w_cand_idx]) begin
            any               = 1'b1;
            idx               = w_cand_idx;
            grant[w_cand_idx] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fp_gpio_sched.sv
`default_nettype none
// ============================================================================
// Module   : fp_gpio_sched
// Brief    : Round-robin time-slot scheduler sharing the front-panel GPIO output.
// Revision : 1.0
// ============================================================================
module fp_gpio_sched
   import fp_gpio_pkg::*;
#(
   parameter int                        GPIO_REG_WIDTH = C_GPIO_REG_WIDTH,
   parameter int                        NUM_REQ        = 4,
   parameter int                        CNT_WIDTH      = 16,
   parameter int                        GUARD_CYC      = 2,
   parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK       = C_OUT_MASK,
   parameter logic [GPIO_REG_WIDTH-1:0] IO_DDR         = C_IO_DDR
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*GPIO_REG_WIDTH-1:0] req_data,
   input  logic [NUM_REQ*CNT_WIDTH-1:0]      req_hold,
   input  logic [GPIO_REG_WIDTH-1:0]         idle_val,
   input  logic                              abort,
   output logic [GPIO_REG_WIDTH-1:0]         fp_gpio_out,
   output logic [GPIO_REG_WIDTH-1:0]         fp_gpio_ddr,
   output logic [$clog2(NUM_REQ)-1:0]        grant_id,
   output logic                              busy,
   output logic                              slot_done
);

   localparam int              C_IW         = $clog2(NUM_REQ);
   localparam int              C_GW         = $clog2(GUARD_CYC + 1);
   localparam logic [C_GW-1:0] C_GUARD_LOAD = C_GW'(GUARD_CYC - 1);

   state_t                    r_state;
   logic [C_IW-1:0]           r_ptr;
   logic [C_IW-1:0]           r_grant;
   logic [CNT_WIDTH-1:0]      r_hold_cnt;
   logic [C_GW-1:0]           r_guard_cnt;
   logic [GPIO_REG_WIDTH-1:0] r_data;
   logic [GPIO_REG_WIDTH-1:0] r_out;

   logic [NUM_REQ-1:0]        w_grant;
   logic [C_IW-1:0]           w_idx;
   logic                      w_any;
   logic                      w_take;
   logic                      w_end;
   logic [GPIO_REG_WIDTH-1:0] w_win_data;
   logic [CNT_WIDTH-1:0]      w_win_hold;
   logic [GPIO_REG_WIDTH-1:0] w_idle;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req   (req_valid),
      .ptr   (r_ptr),
      .grant (w_grant),
      .idx   (w_idx),
      .any   (w_any)
   );

   assign w_take     = (r_state == ST_IDLE) && w_any;
   assign w_win_data = req_data[int'(w_idx)*GPIO_REG_WIDTH +: GPIO_REG_WIDTH];
   assign w_win_hold = req_hold[int'(w_idx)*CNT_WIDTH +: CNT_WIDTH];
   assign w_idle     = idle_val & OUT_MASK;
   // Abort is honoured in the same cycle, so the end-of-slot decision stays combinational.
   assign w_end      = (r_state == ST_DRIVE) && ((r_hold_cnt == '0) || abort);

   assign req_ready   = (r_state == ST_IDLE) ? w_grant : '0;
   assign fp_gpio_out = r_out;
   assign fp_gpio_ddr = IO_DDR;
   assign grant_id    = r_grant;
   assign busy        = (r_state != ST_IDLE);
   assign slot_done   = w_end;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_ptr       <= C_IW'(NUM_REQ - 1);
         r_grant     <= '0;
         r_hold_cnt  <= '0;
         r_guard_cnt <= '0;
         r_data      <= '0;
         r_out       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  r_state    <= ST_DRIVE;
                  r_ptr      <= w_idx;
                  r_grant    <= w_idx;
                  r_data     <= w_win_data;
                  // Hold of zero still yields a single drive cycle.
                  r_hold_cnt <= (w_win_hold == '0) ? '0 : w_win_hold - CNT_WIDTH'(1);
                  r_out      <= w_win_data & OUT_MASK;
               end else begin
                  r_out <= w_idle;
               end
            end
            ST_DRIVE: begin
               if (w_end) begin
                  r_state     <= ST_GUARD;
                  r_guard_cnt <= C_GUARD_LOAD;
                  r_out       <= w_idle;
               end else begin
                  r_hold_cnt <= r_hold_cnt - CNT_WIDTH'(1);
                  r_out      <= r_data & OUT_MASK;
               end
            end
            ST_GUARD: begin
               r_out <= w_idle;
               if (r_guard_cnt == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_guard_cnt <= r_guard_cnt - C_GW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_out   <= w_idle;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fp_gpio_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_gpio_sched
// Brief    : Directed bench for fp_gpio_sched with an interval-based slot model.
// Revision : 1.0
// ============================================================================
module tb_fp_gpio_sched;

   localparam int          W    = 12;
   localparam int          N    = 4;
   localparam int          CW   = 16;
   localparam int          G    = 2;
   localparam logic [11:0] MASK = 12'h011;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_data;
   logic [N*CW-1:0] req_hold;
   logic [W-1:0]   idle_val;
   logic           abort;
   logic [W-1:0]   fp_gpio_out;
   logic [W-1:0]   fp_gpio_ddr;
   logic [1:0]     grant_id;
   logic           busy;
   logic           slot_done;

   fp_gpio_sched dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_data    (req_data),
      .req_hold    (req_hold),
      .idle_val    (idle_val),
      .abort       (abort),
      .fp_gpio_out (fp_gpio_out),
      .fp_gpio_ddr (fp_gpio_ddr),
      .grant_id    (grant_id),
      .busy        (busy),
      .slot_done   (slot_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model: each slot is a pair of cycle intervals [d_lo,d_hi] drive, (d_hi,g_hi] guard.
   int         cyc;
   int         d_lo, d_hi, g_hi;
   int         m_ptr;
   logic [1:0] m_grant;
   logic [W-1:0] m_data, m_out;

   int exp_rr_a [5] = '{0, 1, 2, 3, 0};
   int exp_rr_b [3] = '{1, 3, 1};
   int got_rr   [5];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_step();
      logic [N-1:0] e_ready;
      logic [CW-1:0] h;
      bit drv, grd;
      int w;
      chk("ddr", fp_gpio_ddr, 12'h011);
      if (!reset_n) begin
         chk("m_rst_out", fp_gpio_out, 0);
         chk("m_rst_busy", busy, 0);
         chk("m_rst_done", slot_done, 0);
         chk("m_rst_grant", grant_id, 0);
         m_out = '0; m_grant = '0; m_ptr = N - 1;
         d_lo = -100; d_hi = -100; g_hi = -100; cyc = 0;
      end else begin
         drv = (cyc >= d_lo) && (cyc <= d_hi);
         grd = (cyc > d_hi) && (cyc <= g_hi);
         e_ready = '0;
         w = -1;
         if (!drv && !grd) begin
            for (int k = 1; k <= N; k++) begin
               if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
         end
         if (w >= 0) e_ready[w] = 1'b1;
         if (drv && abort) begin
            d_hi = cyc;
            g_hi = cyc + G;
         end
         chk("m_ready", req_ready, e_ready);
         chk("m_done", slot_done, drv && (cyc == d_hi));
         chk("m_busy", busy, drv || grd);
         chk("m_out", fp_gpio_out, m_out);
         chk("m_grant", grant_id, m_grant);
         if (w >= 0) begin
            m_grant = 2'(w);
            m_ptr   = w;
            m_data  = req_data[w*W +: W];
            h       = req_hold[w*CW +: CW];
            d_lo    = cyc + 1;
            d_hi    = cyc + ((h == 0) ? 1 : int'(h));
            g_hi    = d_hi + G;
         end
         m_out = ((cyc + 1 >= d_lo) && (cyc + 1 <= d_hi)) ? (m_data & MASK) : (idle_val & MASK);
         cyc++;
      end
   endtask

   task automatic neg();
      @(negedge clk);
      model_step();
   endtask

   task automatic pos();
      @(posedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         neg();
         pos();
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] d, input logic [CW-1:0] h);
      req_data[i*W +: W]  = d;
      req_hold[i*CW +: CW] = h;
   endtask

   task automatic collect(input int want, output int n);
      n = 0;
      for (int t = 0; t < 80 && n < want; t++) begin
         neg();
         if (slot_done === 1'b1) begin
            got_rr[n] = int'(grant_id);
            n++;
         end
         pos();
      end
   endtask

   initial begin
      int n;
      int cnt;
      bit seen;
      reset_n   = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_hold  = '0;
      idle_val  = 12'h010;
      abort     = 1'b0;

      // Reset held for five cycles
      cycles(4);
      neg();
      chk("rst_out", fp_gpio_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_ddr", fp_gpio_ddr, 12'h011);
      pos();
      reset_n = 1'b1;
      cycles(2);

      // Single slot, hold 3
      set_req(0, 12'hFFF, 16'd3);
      req_valid = 4'b0001;
      neg();
      chk("ss_ready", req_ready, 4'b0001);
      pos();
      req_valid = '0;
      for (int d = 1; d <= 3; d++) begin
         neg();
         chk("ss_drive_out", fp_gpio_out, 12'h011);
         chk("ss_done", slot_done, (d == 3));
         pos();
      end
      for (int g = 1; g <= 2; g++) begin
         neg();
         chk("ss_guard_out", fp_gpio_out, 12'h010);
         chk("ss_guard_busy", busy, 1);
         pos();
      end
      neg();
      chk("ss_idle_busy", busy, 0);
      pos();

      // Round-robin from reset
      reset_n = 1'b0;
      cycles(2);
      reset_n = 1'b1;
      cycles(1);
      for (int i = 0; i < N; i++) set_req(i, 12'h001 << i, 16'd1);
      req_valid = 4'b1111;
      collect(5, n);
      chk("rr_a_count", n, 5);
      for (int i = 0; i < 5; i++) chk("rr_a_order", got_rr[i], exp_rr_a[i]);
      req_valid = 4'b1010;
      collect(3, n);
      chk("rr_b_count", n, 3);
      for (int i = 0; i < 3; i++) chk("rr_b_order", got_rr[i], exp_rr_b[i]);
      req_valid = '0;
      cycles(5);

      // Abort in drive cycle 5
      set_req(0, 12'h0F1, 16'd100);
      req_valid = 4'b0001;
      neg();
      pos();
      req_valid = '0;
      cycles(4);
      abort = 1'b1;
      neg();
      chk("ab_done", slot_done, 1);
      chk("ab_out", fp_gpio_out, 12'h011);
      pos();
      neg();
      chk("ab_guard_busy", busy, 1);
      chk("ab_guard_out", fp_gpio_out, 12'h010);
      chk("ab_grant", grant_id, 0);
      pos();
      cycles(2);
      abort = 1'b0;
      cycles(2);

      // Hold of zero gives one drive cycle
      set_req(1, 12'h001, 16'd0);
      req_valid = 4'b0010;
      neg();
      pos();
      req_valid = '0;
      neg();
      chk("h0_done", slot_done, 1);
      chk("h0_out", fp_gpio_out, 12'h001);
      pos();
      neg();
      chk("h0_guard", busy, 1);
      chk("h0_guard_out", fp_gpio_out, 12'h010);
      pos();
      cycles(3);

      // idle_val changed during guard
      set_req(2, 12'hFFF, 16'd2);
      req_valid = 4'b0100;
      neg();
      pos();
      req_valid = '0;
      cycles(2);
      idle_val = 12'h001;
      neg();
      chk("gi_first", fp_gpio_out, 12'h010);
      pos();
      neg();
      chk("gi_second", fp_gpio_out, 12'h001);
      pos();
      cycles(2);
      idle_val = 12'h010;
      cycles(1);

      // Maximum hold
      set_req(3, 12'hFFF, 16'hFFFF);
      req_valid = 4'b1000;
      neg();
      pos();
      req_valid = '0;
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 70000) begin
         neg();
         cnt++;
         if (slot_done === 1'b1) seen = 1'b1;
         pos();
      end
      chk("long_len", cnt, 65535);
      cycles(4);

      // Asynchronous reset in the middle of a slot
      set_req(2, 12'hFFF, 16'd10);
      req_valid = 4'b0100;
      neg();
      pos();
      req_valid = '0;
      cycles(3);
      #1 reset_n = 1'b0;
      #1;
      chk("ar_out", fp_gpio_out, 0);
      chk("ar_busy", busy, 0);
      neg();
      pos();
      neg();
      pos();
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 12'h010, 16'd1);
      req_valid = 4'b1111;
      neg();
      chk("ar_first_ready", req_ready, 4'b0001);
      pos();
      req_valid = '0;
      neg();
      chk("ar_first_grant", grant_id, 0);
      pos();
      cycles(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
